// File: rtl/issue_controller_pkg.sv
// Shared types for the ID->EX issue logic: forwarding selects, writeback
// source encoding, the decoder control-word fields used here, and FSM states.
package issue_controller_pkg;

  typedef enum logic [1:0] {
    FWD_NONE = 2'd0,
    FWD_EX   = 2'd1,
    FWD_MA   = 2'd2
  } fwd_src_t;

  typedef enum logic [1:0] {
    WB_SRC_ALU = 2'd0,
    WB_SRC_MEM = 2'd1,
    WB_SRC_PC  = 2'd2,
    WB_SRC_CSR = 2'd3
  } wb_src_t;

  typedef struct packed {
    logic ra_used;
    logic rb_used;
    logic csr_used;
    logic priv;
    logic halt;
  } control_word_t;

  typedef enum logic [2:0] {
    RUN        = 3'd0,
    DRAIN      = 3'd1,
    SOLO       = 3'd2,
    HALT_DRAIN = 3'd3,
    HALTED     = 3'd4
  } issue_state_t;

  // Operand source for one register read; x0 never forwards, EX beats MA.
  function automatic fwd_src_t fwd_select(
    input logic [4:0] rs,
    input logic       ex_ok,
    input logic [4:0] ex_rd,
    input logic       ma_ok,
    input logic [4:0] ma_rd
  );
    fwd_src_t sel;
    if (rs == 5'd0) begin
      sel = FWD_NONE;
    end else if (ex_ok && (ex_rd == rs)) begin
      sel = FWD_EX;
    end else if (ma_ok && (ma_rd == rs)) begin
      sel = FWD_MA;
    end else begin
      sel = FWD_NONE;
    end
    return sel;
  endfunction

endpackage

// File: rtl/issue_controller_checker.sv
// Runtime checks on the in-flight counter: no retire from an empty pipeline
// and never more than MAX_INFLIGHT outstanding instructions.
module issue_controller_checker #(
  parameter int MAX_INFLIGHT = 3,
  parameter int CNT_W        = 2
) (
  input logic             clk_i,
  input logic             reset_n_i,
  input logic             retire_i,
  input logic [CNT_W-1:0] inflight
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_INFLIGHT);

  // Counter sanity on every active clock edge outside reset.
  always @(posedge clk_i) begin
    if (reset_n_i) begin
      assert (!(retire_i && (inflight == {CNT_W{1'b0}})));
      assert (inflight <= MAX_CNT);
    end
  end

endmodule

// File: rtl/issue_hazard_detect.sv
// Combinational hazard unit: operand forwarding selects and load-use detection
// for the instruction currently sitting in ID.
module issue_hazard_detect
  import issue_controller_pkg::*;
(
  input  logic          id_valid,
  input  logic          ra_used,
  input  logic          rb_used,
  input  logic [4:0]    id_rs1,
  input  logic [4:0]    id_rs2,
  input  logic          ex_valid,
  input  logic [4:0]    ex_rd,
  input  logic          ex_wb_valid,
  input  wb_src_t       ex_wb_src,
  input  logic          ma_valid,
  input  logic [4:0]    ma_rd,
  input  logic          ma_wb_valid,
  output fwd_src_t      fwd_a,
  output fwd_src_t      fwd_b,
  output logic          load_use
);

  logic ex_fwd_ok_s;
  logic ma_fwd_ok_s;
  logic ex_load_s;

  // Forward selects and load-use; a load in EX has no data yet, so it only
  // ever stalls. A load targeting x0 writes nothing and cannot cause a hazard.
  always_comb begin
    ex_fwd_ok_s = ex_valid && ex_wb_valid && (ex_wb_src != WB_SRC_MEM);
    ma_fwd_ok_s = ma_valid && ma_wb_valid;
    ex_load_s   = ex_valid && ex_wb_valid && (ex_wb_src == WB_SRC_MEM) && (ex_rd != 5'd0);
    fwd_a       = fwd_select(id_rs1, ex_fwd_ok_s, ex_rd, ma_fwd_ok_s, ma_rd);
    fwd_b       = fwd_select(id_rs2, ex_fwd_ok_s, ex_rd, ma_fwd_ok_s, ma_rd);
    load_use    = id_valid && ex_load_s &&
                  ((ra_used && (ex_rd == id_rs1)) || (rb_used && (ex_rd == id_rs2)));
  end

endmodule

// File: rtl/issue_controller.sv
// ID->EX issue sequencer: hazard stalls, CSR/privileged serialization, halt
// drain and the issued-not-retired counter.
module issue_controller
  import issue_controller_pkg::*;
#(
  parameter int MAX_INFLIGHT = 3,
  localparam int CNT_W = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               id_valid_i,
  input  control_word_t      id_cw_i,
  input  logic [4:0]         id_rs1_i,
  input  logic [4:0]         id_rs2_i,
  input  logic               ex_valid_i,
  input  logic [4:0]         ex_rd_i,
  input  logic               ex_wb_valid_i,
  input  wb_src_t            ex_wb_src_i,
  input  logic               ma_valid_i,
  input  logic [4:0]         ma_rd_i,
  input  logic               ma_wb_valid_i,
  input  logic               retire_i,
  input  logic               redirect_i,
  output logic               issue_o,
  output logic               id_stall_o,
  output logic               id_flush_o,
  output fwd_src_t           fwd_a_o,
  output fwd_src_t           fwd_b_o,
  output logic               halted_o,
  output logic [CNT_W-1:0]   inflight_o
);

  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_INFLIGHT);
  localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);
  localparam logic [CNT_W-1:0] ZERO_CNT = {CNT_W{1'b0}};

  issue_state_t     state_r;
  issue_state_t     state_next_s;
  logic [CNT_W-1:0] inflight_r;
  logic [CNT_W-1:0] inflight_next_s;
  fwd_src_t         fwd_a_s;
  fwd_src_t         fwd_b_s;
  logic             load_use_s;
  logic             room_s;
  logic             serial_s;
  logic             empty_s;

  issue_hazard_detect u_hazard (
    .id_valid    (id_valid_i),
    .ra_used     (id_cw_i.ra_used),
    .rb_used     (id_cw_i.rb_used),
    .id_rs1      (id_rs1_i),
    .id_rs2      (id_rs2_i),
    .ex_valid    (ex_valid_i),
    .ex_rd       (ex_rd_i),
    .ex_wb_valid (ex_wb_valid_i),
    .ex_wb_src   (ex_wb_src_i),
    .ma_valid    (ma_valid_i),
    .ma_rd       (ma_rd_i),
    .ma_wb_valid (ma_wb_valid_i),
    .fwd_a       (fwd_a_s),
    .fwd_b       (fwd_b_s),
    .load_use    (load_use_s)
  );

  issue_controller_checker #(
    .MAX_INFLIGHT (MAX_INFLIGHT),
    .CNT_W        (CNT_W)
  ) u_checker (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .retire_i  (retire_i),
    .inflight  (inflight_r)
  );

  // Issue decision, stall/flush outputs and next state from state + inputs.
  always_comb begin
    room_s       = (inflight_r < MAX_CNT) || retire_i;
    serial_s     = id_cw_i.csr_used || id_cw_i.priv;
    empty_s      = (inflight_r == ZERO_CNT);
    issue_o      = 1'b0;
    id_stall_o   = 1'b0;
    id_flush_o   = 1'b0;
    halted_o     = 1'b0;
    fwd_a_o      = fwd_a_s;
    fwd_b_o      = fwd_b_s;
    state_next_s = state_r;
    if (!reset_n_i) begin
      id_stall_o = 1'b1;
      id_flush_o = 1'b1;
      fwd_a_o    = FWD_NONE;
      fwd_b_o    = FWD_NONE;
    end else if (redirect_i) begin
      // Wrong-path ID instruction: squash it; a pending serial/halt was bogus.
      id_flush_o = 1'b1;
      halted_o   = (state_r == HALTED);
      case (state_r)
        DRAIN, HALT_DRAIN: state_next_s = RUN;
        default:           state_next_s = state_r;
      endcase
    end else begin
      case (state_r)
        RUN: begin
          if (!id_valid_i) begin
            state_next_s = RUN;
          end else if (id_cw_i.halt) begin
            id_stall_o   = 1'b1;
            state_next_s = HALT_DRAIN;
          end else if (serial_s) begin
            if (!empty_s || load_use_s) begin
              id_stall_o   = 1'b1;
              state_next_s = empty_s ? RUN : DRAIN;
            end else begin
              issue_o      = 1'b1;
              state_next_s = SOLO;
            end
          end else if (load_use_s || !room_s) begin
            id_stall_o = 1'b1;
          end else begin
            issue_o = 1'b1;
          end
        end
        DRAIN: begin
          if (id_valid_i && empty_s && !load_use_s) begin
            issue_o      = 1'b1;
            state_next_s = SOLO;
          end else begin
            id_stall_o   = id_valid_i;
            state_next_s = DRAIN;
          end
        end
        SOLO: begin
          id_stall_o   = id_valid_i;
          state_next_s = empty_s ? RUN : SOLO;
        end
        HALT_DRAIN: begin
          id_stall_o   = id_valid_i;
          state_next_s = empty_s ? HALTED : HALT_DRAIN;
        end
        HALTED: begin
          halted_o     = 1'b1;
          id_stall_o   = 1'b1;
          state_next_s = HALTED;
        end
        default: begin
          id_stall_o   = 1'b1;
          state_next_s = RUN;
        end
      endcase
    end
  end

  // In-flight count update; a stray retire on an empty pipeline holds at zero.
  always_comb begin
    inflight_next_s = inflight_r;
    case ({issue_o, retire_i})
      2'b10:   inflight_next_s = inflight_r + ONE_CNT;
      2'b01:   inflight_next_s = empty_s ? ZERO_CNT : (inflight_r - ONE_CNT);
      default: inflight_next_s = inflight_r;
    endcase
  end

  // State and counter registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_r    <= RUN;
      inflight_r <= ZERO_CNT;
    end else begin
      state_r    <= state_next_s;
      inflight_r <= inflight_next_s;
    end
  end

  assign inflight_o = inflight_r;

endmodule
